// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit processor.
// Optional macro CTRL_PERF_EN adds cycle and retired-instruction counters (cyc_cnt, ret_cnt).
module multicycle_control #(
    parameter int IW  = 16,
    parameter int OPW = 4
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [IW-1:0] instr_in,
    input  logic          mem_ack,
    input  logic          zero,
    output logic [IW-1:0] ir,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_asel,
    output logic          pc_we,
    output logic [1:0]    pc_src,
    output logic [OPW-1:0] alu_op,
    output logic          alu_bsel,
    output logic          ext_sign,
    output logic          rf_we,
    output logic          rf_wdsel,
    output logic          illegal,
    output logic [2:0]    state_o
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);
    localparam logic [5:0] OP_AR    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ANDIU = 6'h0D;
    localparam logic [5:0] OP_ORI   = 6'h0E;
    localparam logic [5:0] OP_ORIU  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] F_AND  = 4'h0;
    localparam logic [3:0] F_OR   = 4'h1;
    localparam logic [3:0] F_ADD  = 4'h2;
    localparam logic [3:0] F_SLTU = 4'h3;
    localparam logic [3:0] F_SUB  = 4'h6;
    localparam logic [3:0] F_SLT  = 4'h7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        state_q;
    logic [IW-1:0] ir_q;
    logic          busy_q;
    logic [5:0]    op;
    logic          is_ar, is_j, is_beq, is_br, is_lw, is_sw, is_imm, is_signed, known;
    logic [OPW-1:0] ex_op;

    assign ir      = ir_q;
    assign state_o = state_q;
    assign illegal = state_q == S_TRAP;

    // Opcode classification and EXEC-stage ALU operation from the held instruction.
    always_comb begin
        op        = ir_q[IW-1:IW-6];
        is_ar     = op == OP_AR;
        is_j      = op == OP_J;
        is_beq    = op == OP_BEQ;
        is_br     = is_beq || op == OP_BNE;
        is_lw     = op == OP_LW;
        is_sw     = op == OP_SW;
        is_imm    = op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ANDIU, OP_ORI, OP_ORIU, OP_SLTI, OP_SLTIU};
        is_signed = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        known     = is_ar || is_j || is_br || is_lw || is_sw || is_imm;
        ex_op     = is_ar                              ? OPW'(ir_q[3:0]) :
                    is_br                              ? OPW'(F_SUB)     :
                    op inside {OP_ANDI, OP_ANDIU}      ? OPW'(F_AND)     :
                    op inside {OP_ORI, OP_ORIU}        ? OPW'(F_OR)      :
                    op == OP_SLTI                      ? OPW'(F_SLT)     :
                    op == OP_SLTIU                     ? OPW'(F_SLTU)    : OPW'(F_ADD);
    end

    // Per-state strobes; the fetch request is gated by rst so it drops the instant reset asserts.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_asel = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        alu_op   = '0;
        alu_bsel = 1'b0;
        ext_sign = 1'b0;
        rf_we    = 1'b0;
        rf_wdsel = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = rst && (run || busy_q);
                pc_we   = mem_req && mem_ack;
            end
            S_DECODE: begin
                pc_we  = is_j;
                pc_src = is_j ? 2'd2 : 2'd0;
            end
            S_EXEC: begin
                alu_op   = ex_op;
                alu_bsel = is_imm || is_lw || is_sw;
                ext_sign = is_signed;
                pc_we    = is_br && (is_beq ? zero : !zero);
                pc_src   = is_br ? 2'd1 : 2'd0;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_asel = 1'b1;
                mem_we   = is_sw;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdsel = is_lw;
            end
            default: ;
        endcase
    end

    // Sequencer; busy_q keeps a started fetch alive even if run falls before the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (run || busy_q) begin
                        if (mem_ack) begin
                            ir_q    <= instr_in;
                            busy_q  <= 1'b0;
                            state_q <= S_DECODE;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_DECODE: state_q <= is_j ? S_FETCH : (known ? S_EXEC : S_TRAP);
                S_EXEC:   state_q <= is_br ? S_FETCH : ((is_lw || is_sw) ? S_MEM : S_WB);
                S_MEM:    state_q <= mem_ack ? (is_sw ? S_FETCH : S_WB) : S_MEM;
                S_WB:     state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic             ret_ev;

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
    assign ret_ev  = (state_q == S_DECODE && is_j) || (state_q == S_EXEC && is_br) ||
                     (state_q == S_MEM && mem_ack && is_sw) || state_q == S_WB;

    // Active-cycle and retirement counters, both wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_TRAP && !(state_q == S_FETCH && !run)) cyc_q <= cyc_q + CNT_W'(1);
            if (ret_ev) ret_q <= ret_q + CNT_W'(1);
        end
    end
`endif
endmodule
